// File: rtl/srl_fifo_v2.sv
// srl_fifo_v2 -- SRL-based stream FIFO with occupancy count and registered flags.
//
// Producer writes at if_din/if_write; consumer sees head-of-queue on if_dout with
// first-word fall-through. All flags and the occupancy output are registered from
// the next-state count, so none are combinational from the request inputs.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   if_write_ce/if_write  write enable / request; push when also if_full_n
//   if_din                write data
//   if_full_n             room available this cycle
//   if_almost_full_n      low when occupancy >= AF_THRESH
//   if_read_ce/if_read    read enable / request; pop when also if_empty_n
//   if_dout               head data (zeros when empty)
//   if_empty_n            if_dout valid
//   if_num_data_valid     current occupancy
//
// Build option: define SRL_FIFO_OREG_EN to put a register after the SRL head.
// Capacity grows to DEPTH+1 and write-to-read latency to 2 cycles.
module srl_fifo_v2 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_almost_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH+1:0] AF_C    = (ADDR_WIDTH+2)'(AF_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d, occ_d;
  logic [ADDR_WIDTH-1:0] cnt_lo, head;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  full_n_q, af_n_q;
  logic                  push, srl_pop;

  assign push      = if_write & if_write_ce & full_n_q;
  assign cnt_lo    = cnt_q[ADDR_WIDTH-1:0];
  // Oldest entry sits at count-1; the low bits wrap correctly when count == 2^ADDR_WIDTH.
  assign head      = (cnt_q == '0) ? '0 : cnt_lo - 1'b1;
  assign head_data = mem_q[head];

  // Storage is deliberately not reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = DEPTH-1; i > 0; i--) mem_q[i] <= mem_q[i-1];
      mem_q[0] <= if_din;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !srl_pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && srl_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      full_n_q <= 1'b1;
      af_n_q   <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      full_n_q <= (cnt_d != DEPTH_C);
      af_n_q   <= ({1'b0, occ_d} < AF_C);
    end
  end

  assign if_full_n        = full_n_q;
  assign if_almost_full_n = af_n_q;

`ifdef SRL_FIFO_OREG_EN
  logic                  ovld_q, ovld_d, pop;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
  logic [ADDR_WIDTH:0]   occ_q;

  assign pop     = if_read & if_read_ce & ovld_q;
  // Refill the output register whenever it is empty or being drained this cycle.
  assign srl_pop = (cnt_q != '0) & (~ovld_q | pop);
  assign ovld_d  = srl_pop | (ovld_q & ~pop);
  assign odata_d = srl_pop ? head_data : (ovld_d ? odata_q : '0);
  assign occ_d   = cnt_d + {{ADDR_WIDTH{1'b0}}, ovld_d};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovld_q  <= 1'b0;
      odata_q <= '0;
      occ_q   <= '0;
    end else begin
      ovld_q  <= ovld_d;
      odata_q <= odata_d;
      occ_q   <= occ_d;
    end
  end

  assign if_dout           = odata_q;
  assign if_empty_n        = ovld_q;
  assign if_num_data_valid = occ_q;
`else
  logic empty_n_q;

  assign srl_pop = if_read & if_read_ce & empty_n_q;
  assign occ_d   = cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) empty_n_q <= 1'b0;
    else       empty_n_q <= (cnt_d != '0);
  end

  assign if_dout           = empty_n_q ? head_data : '0;
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = cnt_q;
`endif

endmodule

// File: tb/tb_srl_fifo_v2.sv
module tb_srl_fifo_v2;
  localparam int DW = 32, AW = 4, DEPTH = 16, AF = 14;

  logic          clk = 1'b0, reset = 1'b1;
  logic          wce = 1'b0, wr = 1'b0, rce = 1'b0, rd = 1'b0;
  logic [DW-1:0] din = '0;
  logic          full_n, af_n, empty_n;
  logic [DW-1:0] dout;
  logic [AW:0]   nvalid;

  int checks = 0, failures = 0;

  srl_fifo_v2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk(clk), .reset(reset),
    .if_write_ce(wce), .if_write(wr), .if_din(din),
    .if_full_n(full_n), .if_almost_full_n(af_n),
    .if_read_ce(rce), .if_read(rd),
    .if_dout(dout), .if_empty_n(empty_n), .if_num_data_valid(nvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Checks every output against a plain occupancy/head description.
  task automatic chk_state(input string tag, input int cnt, input logic [31:0] head);
    chk({tag, " count"},   32'(nvalid),  cnt);
    chk({tag, " empty_n"}, 32'(empty_n), 32'(cnt != 0));
    chk({tag, " full_n"},  32'(full_n),  32'(cnt != DEPTH));
    chk({tag, " af_n"},    32'(af_n),    32'(cnt < AF));
    chk({tag, " dout"},    dout,         (cnt != 0) ? head : 32'h0);
  endtask

  // Drive at negedge, take one rising edge, sample 1 time unit later.
  task automatic step(input logic w, input logic wc, input logic [31:0] d,
                      input logic r, input logic rc);
    @(negedge clk);
    wr = w; wce = wc; din = d; rd = r; rce = rc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    wr = 0; wce = 0; rd = 0; rce = 0; din = '0;
  endtask

  typedef struct {
    logic        w, wc;
    logic [31:0] d;
    logic        r, rc;
    int          cnt;
    logic [31:0] head;
  } vec_t;

  vec_t tbl [8];
  logic [31:0] q [$];
  int   wpct, rpct;

  initial begin
    tbl[0] = '{1, 1, 32'h11, 0, 0, 1, 32'h11};  // first push falls through
    tbl[1] = '{0, 0, 32'h00, 1, 0, 1, 32'h11};  // read ce low masks pop
    tbl[2] = '{1, 0, 32'h33, 0, 0, 1, 32'h11};  // write ce low masks push
    tbl[3] = '{1, 1, 32'h22, 1, 0, 2, 32'h11};  // push while pop masked
    tbl[4] = '{0, 0, 32'h00, 1, 1, 1, 32'h22};  // pop exposes next word
    tbl[5] = '{1, 1, 32'h44, 1, 1, 1, 32'h44};  // simultaneous push+pop
    tbl[6] = '{0, 0, 32'h00, 1, 1, 0, 32'h00};  // drain to empty
    tbl[7] = '{0, 0, 32'h00, 1, 1, 0, 32'h00};  // pop on empty ignored

    #12;
    chk_state("reset", 0, 0);
    @(negedge clk); reset = 0;

    foreach (tbl[i]) begin
      step(tbl[i].w, tbl[i].wc, tbl[i].d, tbl[i].r, tbl[i].rc);
      chk_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].head);
    end
    idle();

    // Empty FIFO, push+pop together: pop is gated, nothing bypasses.
    @(negedge clk);
    wr = 1; wce = 1; din = 32'h55; rd = 1; rce = 1;
    #1 chk("empty req-cycle dout", dout, 32'h0);
    @(posedge clk); #1;
    chk_state("empty push+pop", 1, 32'h55);
    step(0, 0, 0, 1, 1);
    chk_state("empty again", 0, 0);

    // Fill to full, watching almost-full and full thresholds.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 1, i, 0, 0);
      chk_state($sformatf("fill%0d", i), i + 1, 32'h0);
    end
    step(1, 1, 32'h99, 0, 0);
    chk_state("17th push ignored", DEPTH, 32'h0);

    // Full FIFO, push+pop together: push gated, only the pop happens.
    @(negedge clk);
    wr = 1; wce = 1; din = 32'hAA; rd = 1; rce = 1;
    #1 chk("full popped word", dout, 32'h0);
    @(posedge clk); #1;
    chk_state("full push+pop", DEPTH - 1, 32'h1);

    for (int k = 1; k < DEPTH; k++) begin
      @(negedge clk);
      wr = 0; wce = 1; rd = 1; rce = 1;
      #1 chk($sformatf("drain%0d", k), dout, k);
      @(posedge clk); #1;
    end
    chk_state("drained", 0, 0);
    idle();

    // Asynchronous reset with 7 words held.
    for (int i = 0; i < 7; i++) step(1, 1, 32'h100 + i, 0, 0);
    chk_state("pre-reset", 7, 32'h100);
    idle();
    #1 reset = 1;
    #1 chk_state("async reset", 0, 0);
    @(negedge clk); reset = 0;
    step(1, 1, 32'h77, 0, 0);
    chk_state("post-reset push", 1, 32'h77);
    step(0, 0, 0, 1, 1);
    chk_state("post-reset pop", 0, 0);
    idle();

    // Random traffic against a reference queue; phases vary the balance so
    // both full and empty are visited.
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic do_push, do_pop;
      case (c / 2500)
        0:       begin wpct = 50; rpct = 50; end
        1:       begin wpct = 75; rpct = 35; end
        2:       begin wpct = 30; rpct = 75; end
        default: begin wpct = 50; rpct = 50; end
      endcase
      @(negedge clk);
      chk("rnd count",   32'(nvalid),  q.size());
      chk("rnd empty_n", 32'(empty_n), 32'(q.size() != 0));
      chk("rnd full_n",  32'(full_n),  32'(q.size() != DEPTH));
      chk("rnd af_n",    32'(af_n),    32'(q.size() < AF));
      chk("rnd dout",    dout,         (q.size() != 0) ? q[0] : 32'h0);
      wr  = ($urandom_range(99) < 32'(wpct));
      rd  = ($urandom_range(99) < 32'(rpct));
      wce = ($urandom_range(3) != 0);
      rce = ($urandom_range(3) != 0);
      din = $urandom;
      do_push = wr && wce && (q.size() < DEPTH);
      do_pop  = rd && rce && (q.size() > 0);
      @(posedge clk);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(din);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/srl_fifo_v2.md
# srl_fifo_v2

Parametrised SRL-based FIFO used on every inter-task stream and start-token channel of the generated Linear_Layer dataflow kernels. It replaces the bare SRL shift register plus external control with one block that owns the shift storage, occupancy counting, full/empty/almost-full flags, and an occupancy output. It sits between an HLS producer task (write side) and its consumer task (read side) in the same clock domain.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width in bits (1 for start tokens).
- ADDR_WIDTH, 4, SRL read-address width; DEPTH <= 2^ADDR_WIDTH.
- DEPTH, 16, SRL storage entries; legal range 2..2^ADDR_WIDTH.
- AF_THRESH, 14, occupancy at or above which almost_full_n drops; legal range 1..DEPTH.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_write_ce  in  1  write-side clock enable.
- if_write  in  1  producer write request.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  high when a write is accepted this cycle.
- if_almost_full_n  out  1  low when occupancy >= AF_THRESH.
- if_read_ce  in  1  read-side clock enable.
- if_read  in  1  consumer read request.
- if_dout  out  DATA_WIDTH  head-of-queue data.
- if_empty_n  out  1  high when if_dout is valid.
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy.

## Operation
- push = if_write & if_write_ce & if_full_n; pop = if_read & if_read_ce & if_empty_n.
- Storage: DEPTH-entry shift array. On push, all entries shift up one index and if_din enters index 0. Storage is never reset.
- Occupancy count (0..DEPTH): push only +1; pop only -1; push and pop together unchanged; neither unchanged.
- Head address = count-1 (0 when count=0). if_dout = storage[count-1] when if_empty_n=1, else all zeros.
- Flags are registered and updated from the next count: if_empty_n = (count != 0); if_full_n = (count != DEPTH); if_almost_full_n = (count < AF_THRESH). if_num_data_valid = count.
- Full with push+pop requested: if_full_n=0 gates the push. Only the pop happens, count -> DEPTH-1, and the push must be re-presented.
- Empty with push+pop requested: if_empty_n=0 gates the pop. Only the push happens. There is no write-to-read bypass.
- ce low on a side masks that side's request entirely. The other side still operates.
- Order is strictly FIFO. No data is lost or duplicated under any push/pop mix.

## Timing
- Reset (asynchronous assert, released synchronously by the surrounding logic): count=0, if_empty_n=0, if_full_n=1, if_almost_full_n=1, if_num_data_valid=0, if_dout=0. Reset asserted mid-operation discards all contents immediately.
- Write-to-read latency is 1 cycle. After a push at edge N into an empty FIFO, if_empty_n=1 and if_dout=that word after edge N (first-word fall-through).
- A pop at edge N presents the next word (or zeros if now empty) after edge N.
- Flags and if_num_data_valid change only on clk edges (or reset). They are never combinational from request inputs.
- Throughput is one push and one pop per cycle sustained at any occupancy 1..DEPTH-1.

## Configuration
- SRL_FIFO_OREG_EN defined: adds a registered output stage after the SRL head.
  - if_dout comes from a flop.
  - if_empty_n reflects the output register's valid bit.
  - Capacity becomes DEPTH+1 and if_num_data_valid counts the register.
  - The SRL refills the output register whenever it is empty or being popped.
  - Write-to-read latency becomes 2 cycles.
  - Reset clears the register valid bit and sets if_dout=0.
- Undefined: if_dout is combinational from the SRL as described above, with capacity DEPTH.

## Test plan
- Reset, then push 0x11 at cycle 1 -> if_empty_n=1, if_dout=0x11, if_num_data_valid=1 after that edge (2-cycle latency with SRL_FIFO_OREG_EN).
- Push 16 words 0..15 with DEPTH=16, no pops -> if_full_n=0 after the 16th, if_almost_full_n=0 after the 14th. A 17th push is ignored. Popping returns 0..15 in order, and if_empty_n=0 afterwards.
- Full FIFO with push and pop asserted in the same cycle -> count 15, the popped word is 0, and the pushed word is not stored.
- Empty FIFO with push and pop asserted in the same cycle -> count 1, the word is stored, and if_dout=0 in the request cycle.
- Random push/pop at 50% rates with ce toggling for 10k cycles against a reference queue -> data matches exactly, with no overflow or underflow.
- Assert reset asynchronously mid-stream with count=7 -> all outputs return to reset values before the next clk edge, and the following push/pop behaves as from empty.
